// File: rtl/sdp_y_op_chn_arb.sv
// Packet-locked round-robin arbiter sharing the SDP Y operand channel between the
// MUL (src0) and ALU (src1) operand sources, decoupled by a 2-entry output FIFO.
module sdp_y_op_chn_arb #(
  parameter int DW = 128
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          cfg_en,
  input  logic          src0_vld,
  output logic          src0_rdy,
  input  logic [DW-1:0] src0_pd,
  input  logic          src0_last,
  input  logic          src1_vld,
  output logic          src1_rdy,
  input  logic [DW-1:0] src1_pd,
  input  logic          src1_last,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_pd,
  output logic          out_last,
  output logic          out_src,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] pd;
    logic          last;
    logic          src;
  } entry_t;

  state_t     state;
  logic       rr_ptr;
  entry_t     fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_cnt;

  logic       space;
  logic       gnt_vld;
  logic       gnt;
  logic       accept;
  logic       pop;
  entry_t     push_entry;

  // Space depends on registers only, so out_rdy never reaches the source readies.
  assign space = (fifo_cnt != 2'd2);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_en && (src0_vld || src1_vld)) begin
          gnt_vld = 1'b1;
          gnt     = (src0_vld && src1_vld) ? rr_ptr : src1_vld;
        end
      end
      LOCK0: begin
        gnt_vld = 1'b1;
        gnt     = 1'b0;
      end
      LOCK1: begin
        gnt_vld = 1'b1;
        gnt     = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
      end
    endcase
  end

  // Readies are masked by reset so no source sees a grant while reset is held.
  assign src0_rdy = ~nvdla_core_rst & space & gnt_vld & ~gnt;
  assign src1_rdy = ~nvdla_core_rst & space & gnt_vld &  gnt;

  assign accept = gnt ? (src1_vld & src1_rdy) : (src0_vld & src0_rdy);
  assign pop    = (fifo_cnt != 2'd0) & out_rdy;

  always_comb begin
    push_entry.pd   = gnt ? src1_pd   : src0_pd;
    push_entry.last = gnt ? src1_last : src0_last;
    push_entry.src  = gnt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else if (accept) begin
      if (push_entry.last) begin
        state  <= IDLE;
        rr_ptr <= ~gnt;
      end else begin
        state  <= gnt ? LOCK1 : LOCK0;
      end
    end
  end

  // NOTE: the two storage entries are reset so out_pd/out_last/out_src read zero after reset.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_vld  = (fifo_cnt != 2'd0);
  assign out_pd   = fifo_mem[rd_ptr].pd;
  assign out_last = fifo_mem[rd_ptr].last;
  assign out_src  = fifo_mem[rd_ptr].src;
  assign busy     = (state != IDLE) | (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_sdp_y_op_chn_arb.sv
// Bench for sdp_y_op_chn_arb: per-cycle comparison against a queue-based model of
// the arbitration rules, plus directed packet-order scenarios and randomized traffic.
module tb_sdp_y_op_chn_arb;

  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] pd;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] pd;
    logic          last;
    logic          src;
  } obeat_t;

  logic          nvdla_core_clk = 1'b0;
  logic          nvdla_core_rst = 1'b1;
  logic          cfg_en = 1'b0;
  logic          src0_vld = 1'b0;
  logic          src0_rdy;
  logic [DW-1:0] src0_pd = '0;
  logic          src0_last = 1'b0;
  logic          src1_vld = 1'b0;
  logic          src1_rdy;
  logic [DW-1:0] src1_pd = '0;
  logic          src1_last = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_pd;
  logic          out_last;
  logic          out_src;
  logic          busy;

  sdp_y_op_chn_arb #(.DW(DW)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .cfg_en         (cfg_en),
    .src0_vld       (src0_vld),
    .src0_rdy       (src0_rdy),
    .src0_pd        (src0_pd),
    .src0_last      (src0_last),
    .src1_vld       (src1_vld),
    .src1_rdy       (src1_rdy),
    .src1_pd        (src1_pd),
    .src1_last      (src1_last),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_pd         (out_pd),
    .out_last       (out_last),
    .out_src        (out_src),
    .busy           (busy)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Source packet queues, model output FIFO, and the log of beats the DUT delivered.
  beat_t  sq0[$];
  beat_t  sq1[$];
  obeat_t mq[$];
  obeat_t dut_log[$];
  int     owner = -1;
  bit     prio  = 1'b0;
  bit     gate0 = 1'b0;
  bit     gate1 = 1'b0;

  task automatic add_pkt(input bit src, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.pd   = base + DW'(i);
      b.last = (i == len - 1);
      if (src) sq1.push_back(b);
      else     sq0.push_back(b);
    end
  endtask

  task automatic drive_sources();
    src0_vld  = gate0 && (sq0.size() > 0);
    src1_vld  = gate1 && (sq1.size() > 0);
    src0_pd   = '0;
    src0_last = 1'b0;
    src1_pd   = '0;
    src1_last = 1'b0;
    if (sq0.size() > 0) begin
      src0_pd   = sq0[0].pd;
      src0_last = sq0[0].last;
    end
    if (sq1.size() > 0) begin
      src1_pd   = sq1[0].pd;
      src1_last = sq1[0].last;
    end
  endtask

  task automatic model_clear();
    sq0.delete();
    sq1.delete();
    mq.delete();
    owner = -1;
    prio  = 1'b0;
    gate0 = 1'b0;
    gate1 = 1'b0;
  endtask

  // Entered just after a falling edge; compares DUT against the model, then advances one clock.
  task automatic cycle(input string tag);
    bit     full, e0, e1, ev, eb, acc0, acc1;
    obeat_t h;
    drive_sources();
    #1;
    full = (mq.size() == 2);
    e0 = !full && (owner == 0 || (owner < 0 && cfg_en === 1'b1 && src0_vld && (!src1_vld || prio == 1'b0)));
    e1 = !full && (owner == 1 || (owner < 0 && cfg_en === 1'b1 && src1_vld && (!src0_vld || prio == 1'b1)));
    ev = (mq.size() != 0);
    eb = (owner >= 0) || ev;
    n_checks++;
    if (src0_rdy !== e0) $display("FAIL %s src0_rdy got %b exp %b", tag, src0_rdy, e0); else n_pass++;
    n_checks++;
    if (src1_rdy !== e1) $display("FAIL %s src1_rdy got %b exp %b", tag, src1_rdy, e1); else n_pass++;
    n_checks++;
    if (out_vld !== ev) $display("FAIL %s out_vld got %b exp %b", tag, out_vld, ev); else n_pass++;
    n_checks++;
    if (busy !== eb) $display("FAIL %s busy got %b exp %b", tag, busy, eb); else n_pass++;
    if (ev) begin
      h = mq[0];
      n_checks++;
      if ({out_pd, out_last, out_src} !== h)
        $display("FAIL %s out_head got %h/%b/%b exp %h/%b/%b", tag, out_pd, out_last, out_src, h.pd, h.last, h.src);
      else n_pass++;
    end
    if (out_vld === 1'b1 && out_rdy) dut_log.push_back({out_pd, out_last, out_src});
    if (ev && out_rdy) mq.delete(0);
    acc0 = src0_vld && e0;
    acc1 = src1_vld && e1;
    if (acc0) begin
      mq.push_back({src0_pd, src0_last, 1'b0});
      if (src0_last) begin owner = -1; prio = 1'b1; end
      else owner = 0;
    end
    if (acc1) begin
      mq.push_back({src1_pd, src1_last, 1'b1});
      if (src1_last) begin owner = -1; prio = 1'b0; end
      else owner = 1;
    end
    if (src0_vld && src0_rdy === 1'b1) sq0.delete(0);
    if (src1_vld && src1_rdy === 1'b1) sq1.delete(0);
    @(posedge nvdla_core_clk);
    @(negedge nvdla_core_clk);
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || mq.size() > 0 || owner >= 0) && n < max) begin
      cycle(tag);
      n++;
    end
    n_checks++;
    if (n >= max) $display("FAIL %s drain_timeout got %0d cycles exp < %0d", tag, n, max); else n_pass++;
  endtask

  task automatic do_reset();
    nvdla_core_rst = 1'b1;
    model_clear();
    drive_sources();
    @(negedge nvdla_core_clk);
    nvdla_core_rst = 1'b0;
    cfg_en  = 1'b1;
    out_rdy = 1'b1;
    dut_log.delete();
  endtask

  task automatic test_reset();
    @(negedge nvdla_core_clk);
    cfg_en  = 1'b1;
    out_rdy = 1'b1;
    add_pkt(1'b0, 2, 128'h11);
    add_pkt(1'b1, 2, 128'h22);
    gate0 = 1'b1;
    gate1 = 1'b1;
    drive_sources();
    #1;
    n_checks++;
    if (src0_rdy !== 1'b0) $display("FAIL reset src0_rdy got %b exp 0", src0_rdy); else n_pass++;
    n_checks++;
    if (src1_rdy !== 1'b0) $display("FAIL reset src1_rdy got %b exp 0", src1_rdy); else n_pass++;
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL reset out_vld got %b exp 0", out_vld); else n_pass++;
    n_checks++;
    if (out_pd !== '0) $display("FAIL reset out_pd got %h exp 0", out_pd); else n_pass++;
    n_checks++;
    if ({out_last, out_src} !== 2'b00) $display("FAIL reset out_last_src got %b exp 00", {out_last, out_src}); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_packet();
    obeat_t e;
    do_reset();
    add_pkt(1'b0, 3, 128'hA0);
    gate0 = 1'b1;
    repeat (4) cycle("single");
    n_checks++;
    if (dut_log.size() != 3) $display("FAIL single log_len got %0d exp 3", dut_log.size()); else n_pass++;
    for (int i = 0; i < 3 && i < dut_log.size(); i++) begin
      e.pd = 128'hA0 + DW'(i); e.last = (i == 2); e.src = 1'b0;
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL single beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
    // Pointer must now favour src1 when both request.
    add_pkt(1'b0, 1, 128'hA8);
    add_pkt(1'b1, 1, 128'hA9);
    gate1 = 1'b1;
    drive_sources();
    #1;
    n_checks++;
    if ({src0_rdy, src1_rdy} !== 2'b01) $display("FAIL single rr_after got %b exp 01", {src0_rdy, src1_rdy}); else n_pass++;
    run_idle("single_rr", 20);
  endtask

  task automatic test_round_robin();
    obeat_t e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_pkt(1'b0, 2, 128'hB0);
      add_pkt(1'b1, 2, 128'hC0);
    end
    gate0 = 1'b1;
    gate1 = 1'b1;
    run_idle("rr", 40);
    n_checks++;
    if (dut_log.size() != 12) $display("FAIL rr log_len got %0d exp 12", dut_log.size()); else n_pass++;
    for (int i = 0; i < 12 && i < dut_log.size(); i++) begin
      e.src  = (i % 4) >= 2;
      e.last = (i % 2) == 1;
      e.pd   = (e.src ? 128'hC0 : 128'hB0) + DW'(i % 2);
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL rr beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_mid_packet();
    obeat_t e;
    do_reset();
    add_pkt(1'b0, 4, 128'hD0);
    gate0 = 1'b1;
    cycle("mid");
    add_pkt(1'b1, 2, 128'hE0);
    gate1 = 1'b1;
    run_idle("mid", 30);
    n_checks++;
    if (dut_log.size() != 6) $display("FAIL mid log_len got %0d exp 6", dut_log.size()); else n_pass++;
    for (int i = 0; i < 6 && i < dut_log.size(); i++) begin
      e.src  = (i >= 4);
      e.pd   = e.src ? 128'hE0 + DW'(i - 4) : 128'hD0 + DW'(i);
      e.last = (i == 3) || (i == 5);
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL mid beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_stall();
    obeat_t e;
    do_reset();
    add_pkt(1'b0, 4, 128'hF0);
    gate0   = 1'b1;
    out_rdy = 1'b0;
    repeat (5) cycle("stall");
    n_checks++;
    if (sq0.size() != 2) $display("FAIL stall accepted got %0d exp 2", 4 - sq0.size()); else n_pass++;
    drive_sources();
    #1;
    n_checks++;
    if ({src0_rdy, busy} !== 2'b01) $display("FAIL stall rdy_busy got %b exp 01", {src0_rdy, busy}); else n_pass++;
    out_rdy = 1'b1;
    run_idle("stall", 20);
    n_checks++;
    if (dut_log.size() != 4) $display("FAIL stall log_len got %0d exp 4", dut_log.size()); else n_pass++;
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
      e.pd = 128'hF0 + DW'(i); e.last = (i == 3); e.src = 1'b0;
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL stall beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_cfg_en();
    obeat_t e;
    do_reset();
    add_pkt(1'b1, 3, 128'h10);
    gate1 = 1'b1;
    cycle("cfg");
    cfg_en = 1'b0;
    add_pkt(1'b0, 2, 128'h20);
    gate0 = 1'b1;
    repeat (6) cycle("cfg_off");
    n_checks++;
    if (sq1.size() != 0) $display("FAIL cfg src1_left got %0d exp 0", sq1.size()); else n_pass++;
    n_checks++;
    if (sq0.size() != 2) $display("FAIL cfg src0_left got %0d exp 2", sq0.size()); else n_pass++;
    cfg_en = 1'b1;
    run_idle("cfg_on", 20);
    n_checks++;
    if (dut_log.size() != 5) $display("FAIL cfg log_len got %0d exp 5", dut_log.size()); else n_pass++;
    for (int i = 0; i < 5 && i < dut_log.size(); i++) begin
      e.src  = (i < 3) ? 1'b1 : 1'b0;
      e.pd   = (i < 3) ? 128'h10 + DW'(i) : 128'h20 + DW'(i - 3);
      e.last = (i == 2) || (i == 4);
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL cfg beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obeat_t e;
    do_reset();
    add_pkt(1'b0, 4, 128'h30);
    add_pkt(1'b1, 1, 128'h38);
    gate0   = 1'b1;
    gate1   = 1'b1;
    out_rdy = 1'b0;
    repeat (3) cycle("rst_mid_fill");
    nvdla_core_rst = 1'b1;
    drive_sources();
    #1;
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL rst_mid out_vld got %b exp 0", out_vld); else n_pass++;
    n_checks++;
    if ({src0_rdy, src1_rdy} !== 2'b00) $display("FAIL rst_mid rdy got %b exp 00", {src0_rdy, src1_rdy}); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_mid busy got %b exp 0", busy); else n_pass++;
    n_checks++;
    if (out_pd !== '0) $display("FAIL rst_mid out_pd got %h exp 0", out_pd); else n_pass++;
    do_reset();
    add_pkt(1'b0, 1, 128'h40);
    add_pkt(1'b1, 1, 128'h50);
    gate0 = 1'b1;
    gate1 = 1'b1;
    run_idle("rst_mid_after", 20);
    n_checks++;
    if (dut_log.size() != 2) $display("FAIL rst_mid log_len got %0d exp 2", dut_log.size()); else n_pass++;
    for (int i = 0; i < 2 && i < dut_log.size(); i++) begin
      e.src = (i == 1); e.pd = (i == 1) ? 128'h50 : 128'h40; e.last = 1'b1;
      n_checks++;
      if (dut_log[i] !== e) $display("FAIL rst_mid beat%0d got %h exp %h", i, dut_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] base;
    int            sent;
    do_reset();
    sent = 0;
    for (int c = 0; c < 1500; c++) begin
      if (sq0.size() == 0 && $urandom_range(0, 2) == 0) begin
        base = {$urandom(), $urandom(), $urandom(), $urandom()};
        add_pkt(1'b0, $urandom_range(1, 4), base);
      end
      if (sq1.size() == 0 && $urandom_range(0, 2) == 0) begin
        base = {$urandom(), $urandom(), $urandom(), $urandom()};
        add_pkt(1'b1, $urandom_range(1, 4), base);
      end
      gate0   = ($urandom_range(0, 3) != 0);
      gate1   = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      cfg_en  = ($urandom_range(0, 9) != 0);
      cycle("random");
    end
    gate0   = 1'b1;
    gate1   = 1'b1;
    out_rdy = 1'b1;
    cfg_en  = 1'b1;
    run_idle("random_drain", 200);
    sent = dut_log.size();
    n_checks++;
    if (sent < 100) $display("FAIL random delivered got %0d exp >= 100", sent); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_mid_packet();
    test_stall();
    test_cfg_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
